// File: rtl/score_display_driver.sv
// Score capture, serial binary-to-BCD conversion and four-digit multiplexed scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module score_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score,
  input  logic        score_valid,
  output logic        busy,
  output logic [3:0]  an,
  output logic [3:0]  digit
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]    state;
  logic [13:0]   bin;
  logic [15:0]   bcd;
  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_q;
  logic [3:0]    cnt;
  logic [13:0]   score_sat;
  logic [PW-1:0] presc;
  logic [1:0]    scan_idx;
  logic [3:0]    nib;

  assign score_sat = (score > 14'd9999) ? 14'd9999 : score;

  // Double-dabble correction applied before every shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (score_valid) begin
            bin   <= score_sat;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd13)
            state <= DONE;
        end
        DONE: begin
          bcd_q <= bcd;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc    <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign an = ~(4'b0001 << scan_idx);

  always_comb begin
    case (scan_idx)
      2'd0:    nib = bcd_q[3:0];
      2'd1:    nib = bcd_q[7:4];
      2'd2:    nib = bcd_q[11:8];
      default: nib = bcd_q[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz3, lz2, lz1, blank;

  // Ones digit is never blanked so a zero score still shows "0".
  assign lz3 = (bcd_q[15:12] == 4'd0);
  assign lz2 = lz3 && (bcd_q[11:8] == 4'd0);
  assign lz1 = lz2 && (bcd_q[7:4] == 4'd0);

  always_comb begin
    case (scan_idx)
      2'd0:    blank = 1'b0;
      2'd1:    blank = lz1;
      2'd2:    blank = lz2;
      default: blank = lz3;
    endcase
  end

  assign digit = blank ? 4'hF : nib;
`else
  assign digit = nib;
`endif

endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver: decimal reference model checked every cycle,
// plus literal display and busy-width expectations for the directed cases.
module tb_score_display_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] score = '0;
  logic        score_valid = 1'b0;
  logic        busy;
  logic [3:0]  an;
  logic [3:0]  digit;

  int compared = 0;
  int mismatched = 0;

  score_display_driver #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .score(score), .score_valid(score_valid),
    .busy(busy), .an(an), .digit(digit)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: cycles since reset, remaining busy cycles, shown value.
  int  m_t = 0;
  int  m_rem = 0;
  int  m_disp = 0;
  int  m_pend = 0;
  bit  m_on = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_rem = 0; m_disp = 0; m_on = 1;
    end else begin
      m_t++;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_disp = m_pend;
      end else if (score_valid) begin
        m_pend = (int'(score) > 9999) ? 9999 : int'(score);
        m_rem = 15;
      end
    end
  end

  function automatic logic [3:0] exp_digit(int v, int idx);
    int p = 1;
    for (int k = 0; k < idx; k++) p *= 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < p) return 4'hF;
`endif
    return 4'((v / p) % 10);
  endfunction

  int  b_cycles = 0;
  int  b_rises = 0;
  bit  b_prev = 0;

  always @(negedge clk) begin
    if (m_on) begin
      logic [3:0] e_an;
      int idx;
      idx = (m_t / RD) % 4;
      e_an = 4'b1111;
      e_an[idx] = 1'b0;
      chk("model_busy", 16'(busy), 16'(m_rem > 0));
      chk("model_an", 16'(an), 16'(e_an));
      chk("model_digit", 16'(digit), 16'(exp_digit(m_disp, idx)));
    end
    if (busy) b_cycles++;
    if (busy && !b_prev) b_rises++;
    b_prev = busy;
  end

  task automatic load(input int v);
    @(posedge clk); #1;
    score = 14'(v); score_valid = 1'b1;
    @(posedge clk); #1;
    score_valid = 1'b0;
  endtask

  // Watch one full scan period and compare each shown digit to a literal.
  task automatic check_display(input string name, input logic [15:0] expd);
    for (int c = 0; c < 4 * RD; c++) begin
      int idx;
      @(negedge clk);
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) chk({name, "_an_onehot"}, 16'(an), 16'hE);
      else         chk(name, 16'(digit), 16'(expd[4*idx +: 4]));
    end
  endtask

  task automatic load_and_check(input string name, input int v, input logic [15:0] expd);
    int c0, r0;
    c0 = b_cycles; r0 = b_rises;
    load(v);
    repeat (20) @(posedge clk);
    chk({name, "_busy_len"}, 16'(b_cycles - c0), 16'd15);
    chk({name, "_busy_rises"}, 16'(b_rises - r0), 16'd1);
    check_display(name, expd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an_seq [17];
    int c0, r0;
    an_seq = '{4'hE,4'hE,4'hE,4'hE,4'hD,4'hD,4'hD,4'hD,
               4'hB,4'hB,4'hB,4'hB,4'h7,4'h7,4'h7,4'h7,4'hE};

    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("reset_busy", 16'(busy), 16'd0);
        chk("reset_digit", 16'(digit), 16'd0);
      end
      chk("reset_an_step", 16'(an), 16'(an_seq[k]));
    end

    load_and_check("conv_1234", 1234, 16'h1234);
    load_and_check("sat_12000", 12000, 16'h9999);
    load_and_check("max_9999", 9999, 16'h9999);
`ifdef LEADING_ZERO_BLANK_EN
    load_and_check("zero", 0, 16'hFFF0);
    load_and_check("blank_7", 7, 16'hFFF7);
    load_and_check("blank_305", 305, 16'hF305);
`else
    load_and_check("zero", 0, 16'h0000);
    load_and_check("noblank_7", 7, 16'h0007);
    load_and_check("noblank_305", 305, 16'h0305);
`endif

    // Second strobe while busy is dropped.
    c0 = b_cycles; r0 = b_rises;
    load(42);
    repeat (4) @(posedge clk); #1;
    score = 14'd77; score_valid = 1'b1;
    @(posedge clk); #1;
    score_valid = 1'b0;
    repeat (20) @(posedge clk);
    chk("drop_busy_len", 16'(b_cycles - c0), 16'd15);
    chk("drop_busy_rises", 16'(b_rises - r0), 16'd1);
`ifdef LEADING_ZERO_BLANK_EN
    check_display("drop_42", 16'hFF42);
`else
    check_display("drop_42", 16'h0042);
`endif

    // Strobe landing in the DONE cycle is also dropped.
    c0 = b_cycles; r0 = b_rises;
    load(1111);
    repeat (14) @(posedge clk); #1;
    score = 14'd2222; score_valid = 1'b1;
    @(posedge clk); #1;
    score_valid = 1'b0;
    repeat (20) @(posedge clk);
    chk("done_drop_rises", 16'(b_rises - r0), 16'd1);
    check_display("done_drop_1111", 16'h1111);

    // Reset mid-conversion discards the partial result.
    load(5678);
    repeat (6) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 16'(busy), 16'd0);
    repeat (20) @(posedge clk);
`ifdef LEADING_ZERO_BLANK_EN
    check_display("abort_disp", 16'hFFF0);
`else
    check_display("abort_disp", 16'h0000);
`endif
    load_and_check("reload_5678", 5678, 16'h5678);

    // Random traffic: strobes at any time, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      score = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(9990, 16383))
                                          : 14'($urandom_range(0, 9999));
      score_valid = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    score_valid = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
